// File: rtl/poly1305_pkg.sv
// Shared widths, clamp mask and FSM state type for the Poly1305 datapath.
package poly1305_pkg;

    localparam int unsigned ACC_W  = 130;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned SUM_W  = 131;
    localparam int unsigned PROD_W = 258;

    localparam logic [BLK_W-1:0] R_CLAMP_MASK = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

    // Common start/busy/done controller states used across the datapath stages.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } poly_state_e;

    function automatic logic [BLK_W-1:0] clamp_r(input logic [BLK_W-1:0] r);
        return r & R_CLAMP_MASK;
    endfunction

endpackage

// File: rtl/poly1305_digit_mac.sv
// One digit step of the product: p_out = p_in + (s * digit) << shamt.
module poly1305_digit_mac
    import poly1305_pkg::*;
#(
    parameter int unsigned DIGIT_W = 32
) (
    input  logic [SUM_W-1:0]   s_in,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic [7:0]         shamt_in,
    input  logic [PROD_W-1:0]  p_in,
    output logic [PROD_W-1:0]  p_out
);

    localparam int unsigned MUL_W  = SUM_W + DIGIT_W;
    localparam int unsigned WIDE_W = PROD_W + DIGIT_W;

    logic [MUL_W-1:0] prod;

    // Full-width partial product, shifted to its digit position and accumulated.
    // The true product never reaches 2^255, so dropping bits above PROD_W is lossless.
    always_comb begin
        prod  = MUL_W'(s_in) * MUL_W'(digit_in);
        p_out = PROD_W'(WIDE_W'(p_in) + (WIDE_W'(prod) << shamt_in));
    end

endmodule

// File: rtl/poly1305_mult.sv
// Digit-serial (acc + block) x clamp(r) multiplier with start/busy/done handshake.
module poly1305_mult
    import poly1305_pkg::*;
#(
    parameter int unsigned DIGIT_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [BLK_W-1:0]  block_in,
    input  logic              hibit,
    input  logic [BLK_W-1:0]  r_in,
    output logic [PROD_W-1:0] product_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NUM_DIGITS = BLK_W / DIGIT_W;
    localparam int unsigned CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);
    localparam logic [7:0]       DIGIT_W8   = 8'(DIGIT_W);

    poly_state_e state_q, state_d;

    logic [SUM_W-1:0]  s_q, s_d;
    logic [BLK_W-1:0]  r_c_q, r_c_d;
    logic [PROD_W-1:0] p_q, p_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] product_q, product_d;
    logic              done_q, done_d;

    logic [7:0]         shamt;
    logic [DIGIT_W-1:0] digit;
    logic [PROD_W-1:0]  mac_out;
    logic               last_digit;

    // Current digit of clamped r and its bit position in the product.
    always_comb begin
        shamt      = 8'(cnt_q) * DIGIT_W8;
        digit      = DIGIT_W'(r_c_q >> shamt);
        last_digit = (cnt_q == LAST_DIGIT);
    end

    poly1305_digit_mac #(
        .DIGIT_W (DIGIT_W)
    ) u_digit_mac (
        .s_in     (s_q),
        .digit_in (digit),
        .shamt_in (shamt),
        .p_in     (p_q),
        .p_out    (mac_out)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)      state_d = ST_MUL;
            ST_MUL:  if (last_digit) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy        = (state_q == ST_MUL);
        done        = done_q;
        product_out = product_q;
    end

    // Datapath next values: operand capture on start, one digit per MUL cycle.
    always_comb begin
        s_d       = s_q;
        r_c_d     = r_c_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d   = SUM_W'(acc_in) + SUM_W'(block_in) + SUM_W'({hibit, BLK_W'(0)});
                    r_c_d = clamp_r(r_in);
                    p_d   = '0;
                    cnt_d = '0;
                end
            end
            ST_MUL: begin
                p_d   = mac_out;
                cnt_d = cnt_q + 1'b1;
                if (last_digit) begin
                    product_d = mac_out;
                    done_d    = 1'b1;
                    cnt_d     = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q       <= '0;
            r_c_q     <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            s_q       <= s_d;
            r_c_q     <= r_c_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_poly1305_mult.sv
// Self-checking bench for poly1305_mult at DIGIT_W = 8, 32 and 128.
module tb_poly1305_mult;

    localparam logic [127:0] MASK = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [129:0] acc_in;
    logic [127:0] block_in;
    logic         hibit;
    logic [127:0] r_in;

    logic [257:0] prod8, prod32, prod128;
    logic         busy8, busy32, busy128;
    logic         done8, done32, done128;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    poly1305_mult #(.DIGIT_W(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start), .acc_in(acc_in), .block_in(block_in),
        .hibit(hibit), .r_in(r_in), .product_out(prod8), .busy(busy8), .done(done8)
    );

    poly1305_mult #(.DIGIT_W(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .start(start), .acc_in(acc_in), .block_in(block_in),
        .hibit(hibit), .r_in(r_in), .product_out(prod32), .busy(busy32), .done(done32)
    );

    poly1305_mult #(.DIGIT_W(128)) u_dut128 (
        .clk(clk), .reset_n(reset_n), .start(start), .acc_in(acc_in), .block_in(block_in),
        .hibit(hibit), .r_in(r_in), .product_out(prod128), .busy(busy128), .done(done128)
    );

    task automatic check_eq(input string tag, input logic [257:0] got, input logic [257:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [257:0] model(input logic [129:0] a, input logic [127:0] b,
                                           input logic h, input logic [127:0] r);
        logic [257:0] s;
        logic [257:0] rc;
        s  = 258'(a) + 258'(b) + (258'(h) << 128);
        rc = 258'(r & MASK);
        return s * rc;
    endfunction

    task automatic drive(input logic [129:0] a, input logic [127:0] b,
                         input logic h, input logic [127:0] r);
        acc_in   = a;
        block_in = b;
        hibit    = h;
        r_in     = r;
    endtask

    function automatic logic [129:0] rand130();
        return 130'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one operation to all three widths; all must be idle beforehand.
    task automatic run_all(input string tag, input logic [129:0] a, input logic [127:0] b,
                           input logic h, input logic [127:0] r, input logic [257:0] exp);
        int lat8, lat32, lat128;
        logic [257:0] cap8, cap32, cap128;
        lat8 = 0; lat32 = 0; lat128 = 0;
        cap8 = '0; cap32 = '0; cap128 = '0;
        drive(a, b, h, r);
        start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble inputs: the operation must use only the values sampled at start.
        drive(rand130(), rand128(), 1'($urandom), rand128());
        check_eq({tag, "_busy0"}, 258'(busy32), 258'(1));
        for (int c = 1; c <= 40; c++) begin
            tick();
            if ((done8 && busy8) || (done32 && busy32) || (done128 && busy128))
                check_eq({tag, "_done_and_busy"}, 258'(1), 258'(0));
            if (done8 && lat8 == 0)     begin lat8 = c;   cap8 = prod8;     end
            if (done32 && lat32 == 0)   begin lat32 = c;  cap32 = prod32;   end
            if (done128 && lat128 == 0) begin lat128 = c; cap128 = prod128; end
            if (c < 4) check_eq({tag, "_busy"}, 258'(busy32), 258'(1));
            if (lat8 != 0 && lat32 != 0 && lat128 != 0) break;
        end
        check_eq({tag, "_lat8"},   258'(lat8),   258'(16));
        check_eq({tag, "_lat32"},  258'(lat32),  258'(4));
        check_eq({tag, "_lat128"}, 258'(lat128), 258'(1));
        check_eq({tag, "_p8"},   cap8,   exp);
        check_eq({tag, "_p32"},  cap32,  exp);
        check_eq({tag, "_p128"}, cap128, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [257:0] exp;
        logic [129:0] a;
        logic [127:0] b, r;
        logic         h;
        int           ndone;

        reset_n = 1'b0;
        start   = 1'b0;
        drive('0, '0, 1'b0, '0);
        tick();
        tick();
        check_eq("rst_prod", prod32, '0);
        check_eq("rst_busy", 258'(busy32), 258'(0));
        check_eq("rst_done", 258'(done32), 258'(0));
        reset_n = 1'b1;
        tick();

        run_all("basic", '0, 128'd1, 1'b0, 128'd1, 258'd1);
        run_all("hibit", '0, '0, 1'b1, 128'd2, 258'(1) << 129);
        run_all("clamp", '0, 128'd1, 1'b0, '1, 258'(MASK));
        exp = ((258'(1) << 130) + (258'(1) << 129) - 258'd2) * 258'(MASK);
        run_all("maxop", '1, '1, 1'b1, '1, exp);
        check_eq("maxop_top", 258'(prod32[257:255]), 258'(0));

        // Start during busy is ignored; start the cycle after done is accepted.
        a = rand130(); b = rand128(); h = 1'b1; r = rand128();
        exp = model(a, b, h, r);
        drive(a, b, h, r);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        drive(rand130(), rand128(), 1'b0, rand128());
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("hs_busy_t3", 258'(busy32), 258'(1));
        tick();
        check_eq("hs_done_t4", 258'(done32), 258'(1));
        check_eq("hs_busy_t4", 258'(busy32), 258'(0));
        check_eq("hs_first", prod32, exp);
        a = rand130(); b = rand128(); h = 1'b0; r = rand128();
        exp = model(a, b, h, r);
        drive(a, b, h, r);
        start = 1'b1;
        tick();
        start = 1'b0;
        drive(rand130(), rand128(), 1'b1, rand128());
        check_eq("b2b_done_clr", 258'(done32), 258'(0));
        check_eq("b2b_busy", 258'(busy32), 258'(1));
        tick();
        tick();
        tick();
        tick();
        check_eq("b2b_done", 258'(done32), 258'(1));
        check_eq("b2b_prod", prod32, exp);
        for (int i = 0; i < 24; i++) tick();

        // Reset mid-operation aborts immediately and produces no done pulse.
        drive(rand130(), rand128(), 1'b1, rand128());
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_eq("rstmid_busy", 258'(busy32), 258'(0));
        check_eq("rstmid_done", 258'(done32), 258'(0));
        check_eq("rstmid_prod", prod32, '0);
        check_eq("rstmid_prod8", prod8, '0);
        tick();
        tick();
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done8 || done32 || done128) ndone++;
        end
        check_eq("rstmid_nodone", 258'(ndone), 258'(0));
        run_all("post_rst", '0, 128'd5, 1'b1, 128'h3, model('0, 128'd5, 1'b1, 128'h3));

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 12; i++) begin
            a = (i % 4 == 0) ? '1 : rand130();
            b = (i % 5 == 0) ? '1 : rand128();
            h = 1'($urandom);
            r = (i % 3 == 0) ? '1 : rand128();
            run_all("rand", a, b, h, r, model(a, b, h, r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
